// File: rtl/led_pattern_seq.sv
// ---------------------------------------------------------------------------
// led_pattern_seq
//   LED pattern sequencer for the lab display LED bank. A prescaler divides
//   clk down to a step rate. On every step the LED pattern advances according
//   to the selected mode: bounce, rotate right, rotate left or fill.
//
//   Optional build macro LED_PWM_DIM_EN adds a 4-bit brightness input. The
//   LED bank is then gated by a free-running 16-cycle PWM.
//
// Parameters
//   WIDTH  number of LEDs (2..32)
//   DIV_W  prescaler reload/counter width
//
// Ports
//   clk     system clock
//   reset   asynchronous, active-high reset
//   en      run enable; low freezes prescaler and pattern
//   mode    00 bounce, 01 rotate right, 10 rotate left, 11 fill
//   div     prescaler terminal count; one step every div+1 cycles
//   bright  (LED_PWM_DIM_EN only) PWM duty, bright/16
//   led     LED drive, bit WIDTH-1 = leftmost LED
//   dir     bounce direction, 0 = toward LSB, 1 = toward MSB
//   step    one-cycle pulse on every pattern update
//   wrap    one-cycle pulse on end-of-sweep, coincident with step
// ---------------------------------------------------------------------------
module led_pattern_seq #(
   parameter int WIDTH = 8,
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
`ifdef LED_PWM_DIM_EN
   input  logic [3:0]       bright,
`endif
   output logic [WIDTH-1:0] led,
   output logic             dir,
   output logic             step,
   output logic             wrap
);

   generate
      if (WIDTH < 2 || WIDTH > 32) begin : g_width_check
         $error("led_pattern_seq: WIDTH must be in 2..32");
      end
   endgenerate

   typedef enum logic [1:0] {
      MODE_BOUNCE = 2'b00,
      MODE_ROT_R  = 2'b01,
      MODE_ROT_L  = 2'b10,
      MODE_FILL   = 2'b11
   } mode_e;

   localparam logic [WIDTH-1:0] LED_MSB = {1'b1, {(WIDTH-1){1'b0}}};

   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic [WIDTH-1:0] led_q, led_nxt;
   logic [WIDTH-1:0] led_inv;
   logic             dir_nxt, wrap_nxt;
   logic             tick;
   logic             therm_ok, legal;

   // A thermometer from the MSB inverts to a run of ones from the LSB
   // (possibly empty or full). Such a value has no bit set in common with
   // itself plus one.
   assign led_inv  = ~led_q;
   assign therm_ok = ((led_inv & (led_inv + WIDTH'(1))) == '0);
   assign legal    = (mode_e'(mode) == MODE_FILL) ? therm_ok : $onehot(led_q);

   always_comb begin
      cnt_nxt  = cnt;
      led_nxt  = led_q;
      dir_nxt  = dir;
      wrap_nxt = 1'b0;
      tick     = 1'b0;

      if (en) begin
         // Exact compare only. If div drops below cnt, cnt runs on to
         // all-ones and wraps to 0 before it matches again.
         if (cnt == div) begin
            cnt_nxt = '0;
            tick    = 1'b1;
         end else begin
            cnt_nxt = cnt + DIV_W'(1);
         end
      end

      if (tick) begin
         if (!legal) begin
            // Recovers from reset, from a mid-run mode change or from any
            // corrupted pattern.
            led_nxt = LED_MSB;
            dir_nxt = 1'b0;
         end else begin
            case (mode_e'(mode))
               MODE_BOUNCE: begin
                  if (!dir && led_q[0]) begin
                     dir_nxt  = 1'b1;
                     led_nxt  = led_q << 1;
                     wrap_nxt = 1'b1;
                  end else if (dir && led_q[WIDTH-1]) begin
                     dir_nxt  = 1'b0;
                     led_nxt  = led_q >> 1;
                     wrap_nxt = 1'b1;
                  end else if (dir) begin
                     led_nxt = led_q << 1;
                  end else begin
                     led_nxt = led_q >> 1;
                  end
               end
               MODE_ROT_R: begin
                  led_nxt  = {led_q[0], led_q[WIDTH-1:1]};
                  wrap_nxt = led_q[0];
                  dir_nxt  = 1'b0;
               end
               MODE_ROT_L: begin
                  led_nxt  = {led_q[WIDTH-2:0], led_q[WIDTH-1]};
                  wrap_nxt = led_q[WIDTH-1];
                  dir_nxt  = 1'b1;
               end
               default: begin
                  if (&led_q) begin
                     led_nxt  = '0;
                     wrap_nxt = 1'b1;
                  end else begin
                     led_nxt = {1'b1, led_q[WIDTH-1:1]};
                  end
                  dir_nxt = 1'b0;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         led_q <= '0;
         dir   <= 1'b0;
         step  <= 1'b0;
         wrap  <= 1'b0;
      end else begin
         cnt   <= cnt_nxt;
         led_q <= led_nxt;
         dir   <= dir_nxt;
         step  <= tick;
         wrap  <= wrap_nxt;
      end
   end

`ifdef LED_PWM_DIM_EN
   logic [3:0]       pwm;
   logic [3:0]       pwm_nxt;
   logic [WIDTH-1:0] led_dim;

   assign pwm_nxt = pwm + 4'd1;

   // The gate uses next-cycle values so the registered output lines up
   // with the led_q and pwm registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pwm     <= 4'd0;
         led_dim <= '0;
      end else begin
         pwm     <= pwm_nxt;
         led_dim <= led_nxt & {WIDTH{pwm_nxt < bright}};
      end
   end

   assign led = led_dim;
`else
   assign led = led_q;
`endif

endmodule

// File: tb/tb_led_pattern_seq.sv
module tb_led_pattern_seq;

   logic        clk = 1'b0;
   logic        reset, en;
   logic [1:0]  mode;
   logic [23:0] div;
   logic [3:0]  bright;
   logic [7:0]  led;
   logic        dir, step, wrap;

   logic        reset2, en2;
   logic [1:0]  mode2;
   logic [23:0] div2;
   logic [1:0]  led2;
   logic        dir2, step2, wrap2;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   led_pattern_seq #(.WIDTH(8), .DIV_W(24)) dut (
      .clk(clk), .reset(reset), .en(en), .mode(mode), .div(div),
`ifdef LED_PWM_DIM_EN
      .bright(bright),
`endif
      .led(led), .dir(dir), .step(step), .wrap(wrap)
   );

   led_pattern_seq #(.WIDTH(2), .DIV_W(24)) dut2 (
      .clk(clk), .reset(reset2), .en(en2), .mode(mode2), .div(div2),
`ifdef LED_PWM_DIM_EN
      .bright(bright),
`endif
      .led(led2), .dir(dir2), .step(step2), .wrap(wrap2)
   );

   // With dimming built in, the sequencing checks look at the undimmed pattern.
   logic [7:0] led_obs;
`ifdef LED_PWM_DIM_EN
   assign led_obs = dut.led_q;
`else
   assign led_obs = led;
`endif

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic restart(input logic [1:0] m);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      mode  = m;
      div   = '0;
      en    = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      en = 1'b1; mode = 2'b00; div = '0;
      repeat (3) cyc();
      n_cmp++;
      if ({led_obs, dir, step, wrap} !== 11'b0) begin
         n_err++;
         $display("FAIL reset_state: got led=%h dir=%b step=%b wrap=%b, want all 0",
                  led_obs, dir, step, wrap);
      end
      reset = 1'b0;
   endtask

   task automatic test_bounce();
      logic [7:0]  exp_led [16] = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01,
                                   8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40};
      logic [15:0] exp_dir  = 16'b0111_1111_0000_0000;
      logic [15:0] exp_wrap = 16'b1000_0001_0000_0000;
      for (int i = 0; i < 16; i++) begin
         cyc();
         n_cmp++;
         if ({led_obs, dir, step, wrap} !== {exp_led[i], exp_dir[i], 1'b1, exp_wrap[i]}) begin
            n_err++;
            $display("FAIL bounce[%0d]: got led=%h dir=%b step=%b wrap=%b, want led=%h dir=%b step=1 wrap=%b",
                     i, led_obs, dir, step, wrap, exp_led[i], exp_dir[i], exp_wrap[i]);
         end
      end
   endtask

   task automatic test_prescaler();
      logic [7:0] exp_led [8] = '{8'h40, 8'h40, 8'h40, 8'h20, 8'h20, 8'h20, 8'h20, 8'h10};
      div = 24'd3;
      for (int i = 0; i < 8; i++) begin
         cyc();
         n_cmp++;
         if ({led_obs, step} !== {exp_led[i], (i % 4) == 3}) begin
            n_err++;
            $display("FAIL prescaler[%0d]: got led=%h step=%b, want led=%h step=%b",
                     i, led_obs, step, exp_led[i], (i % 4) == 3);
         end
      end
      repeat (2) cyc();
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_cmp++;
         if ({led_obs, step, wrap} !== {8'h10, 2'b00}) begin
            n_err++;
            $display("FAIL freeze[%0d]: got led=%h step=%b wrap=%b, want led=10 step=0 wrap=0",
                     i, led_obs, step, wrap);
         end
      end
      en = 1'b1;
      cyc();
      n_cmp++;
      if ({led_obs, step} !== {8'h10, 1'b0}) begin
         n_err++;
         $display("FAIL resume_wait: got led=%h step=%b, want led=10 step=0", led_obs, step);
      end
      cyc();
      n_cmp++;
      if ({led_obs, step} !== {8'h08, 1'b1}) begin
         n_err++;
         $display("FAIL resume_step: got led=%h step=%b, want led=08 step=1", led_obs, step);
      end
   endtask

   task automatic test_rotate();
      logic [7:0] exp_led [5] = '{8'h80, 8'h01, 8'h02, 8'h01, 8'h80};
      logic [4:0] exp_dir  = 5'b00110;
      logic [4:0] exp_wrap = 5'b10010;
      restart(2'b10);
      for (int i = 0; i < 5; i++) begin
         if (i == 3) mode = 2'b01;
         cyc();
         n_cmp++;
         if ({led_obs, dir, step, wrap} !== {exp_led[i], exp_dir[i], 1'b1, exp_wrap[i]}) begin
            n_err++;
            $display("FAIL rotate[%0d]: got led=%h dir=%b step=%b wrap=%b, want led=%h dir=%b step=1 wrap=%b",
                     i, led_obs, dir, step, wrap, exp_led[i], exp_dir[i], exp_wrap[i]);
         end
      end
   endtask

   task automatic test_fill();
      logic [7:0]  exp_led [13] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
                                    8'h00, 8'h80, 8'hC0, 8'hE0, 8'h80};
      logic [12:0] exp_wrap = 13'b0_0001_0000_0000;
      restart(2'b11);
      for (int i = 0; i < 13; i++) begin
         if (i == 12) mode = 2'b00;
         cyc();
         n_cmp++;
         if ({led_obs, dir, step, wrap} !== {exp_led[i], 1'b0, 1'b1, exp_wrap[i]}) begin
            n_err++;
            $display("FAIL fill[%0d]: got led=%h dir=%b step=%b wrap=%b, want led=%h dir=0 step=1 wrap=%b",
                     i, led_obs, dir, step, wrap, exp_led[i], exp_wrap[i]);
         end
      end
   endtask

   task automatic test_async_reset();
      restart(2'b00);
      repeat (4) cyc();
      n_cmp++;
      if (led_obs !== 8'h10) begin
         n_err++;
         $display("FAIL pre_reset: got led=%h, want 10", led_obs);
      end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({led_obs, dir, step, wrap} !== 11'b0) begin
         n_err++;
         $display("FAIL async_reset: got led=%h dir=%b step=%b wrap=%b, want all 0",
                  led_obs, dir, step, wrap);
      end
      cyc();
      reset = 1'b0;
      cyc();
      n_cmp++;
      if ({led_obs, dir, step, wrap} !== {8'h80, 1'b0, 1'b1, 1'b0}) begin
         n_err++;
         $display("FAIL after_reset: got led=%h dir=%b step=%b wrap=%b, want led=80 dir=0 step=1 wrap=0",
                  led_obs, dir, step, wrap);
      end
   endtask

   task automatic test_width2();
      logic [1:0] exp_led [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10};
      logic [4:0] exp_dir  = 5'b10100;
      logic [4:0] exp_wrap = 5'b11100;
      n_cmp++;
      if ({led2, dir2, step2, wrap2} !== 5'b0) begin
         n_err++;
         $display("FAIL w2_reset: got led=%b dir=%b step=%b wrap=%b, want all 0",
                  led2, dir2, step2, wrap2);
      end
      reset2 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cyc();
         n_cmp++;
         if ({led2, dir2, step2, wrap2} !== {exp_led[i], exp_dir[i], 1'b1, exp_wrap[i]}) begin
            n_err++;
            $display("FAIL w2_bounce[%0d]: got led=%b dir=%b step=%b wrap=%b, want led=%b dir=%b step=1 wrap=%b",
                     i, led2, dir2, step2, wrap2, exp_led[i], exp_dir[i], exp_wrap[i]);
         end
      end
   endtask

`ifdef LED_PWM_DIM_EN
   task automatic test_pwm();
      int on_cnt;
      int low_bad;
      on_cnt  = 0;
      low_bad = 0;
      restart(2'b00);
      cyc();
      en = 1'b0;
      repeat (2) cyc();
      for (int i = 0; i < 16; i++) begin
         if (led[7]) on_cnt++;
         if (led[6:0] != 7'd0) low_bad++;
         cyc();
      end
      n_cmp++;
      if (on_cnt !== 4 || low_bad !== 0) begin
         n_err++;
         $display("FAIL pwm_duty: got %0d on-cycles (%0d stray), want 4 (0 stray)", on_cnt, low_bad);
      end
   endtask
`endif

   initial begin
      reset  = 1'b1; en = 1'b0; mode = 2'b00; div = '0; bright = 4'd4;
      reset2 = 1'b1; en2 = 1'b1; mode2 = 2'b00; div2 = '0;
      test_reset();
      test_bounce();
      test_prescaler();
      test_rotate();
      test_fill();
      test_async_reset();
      test_width2();
`ifdef LED_PWM_DIM_EN
      test_pwm();
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
